// File: rtl/edge_grad_if.sv
`default_nettype none
// ============================================================================
//  Module   : edge_grad_if
//  Brief    : Column-sample stream into, and edge-result stream out of,
//             the 3x3 gradient engine.
//  Revision : 1.0
// ============================================================================
interface edge_grad_if #(
    parameter int PIX_W = 8
);
    logic               valid_in;
    logic [PIX_W-1:0]   din1;
    logic [PIX_W-1:0]   din2;
    logic [PIX_W-1:0]   din3;
    logic [3*PIX_W-1:0] dout;
    logic               valid_out;

    modport master (
        output valid_in, din1, din2, din3,
        input  dout, valid_out
    );

    modport slave (
        input  valid_in, din1, din2, din3,
        output dout, valid_out
    );
endinterface
`default_nettype wire

// File: rtl/edge_grad_3x3.sv
`default_nettype none
// ============================================================================
//  Module   : edge_grad_3x3
//  Brief    : Streaming 3x3 Prewitt/Sobel gradient magnitude with optional
//             binarisation; two-cycle latency, no backpressure.
//  Revision : 1.0
// ============================================================================
module edge_grad_3x3 #(
    parameter int PIX_W     = 8,
    parameter int PIC_WIDTH = 640
) (
    input  logic             clk,
    input  logic             rst,
    edge_grad_if.slave       strm,
    input  logic             mode,
    input  logic             bin_en,
    input  logic [PIX_W-1:0] thresh
);
    localparam int c_COL_W = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
    localparam int c_G_W   = PIX_W + 3;
    localparam int c_M_W   = PIX_W + 4;
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(PIC_WIDTH - 1);

    logic [PIX_W-1:0]        r_win [3][3];
    logic [PIX_W-1:0]        w_din [3];
    logic [c_COL_W-1:0]      r_col;
    logic                    r_v0, r_v1, r_b0, r_b1, r_vout;
    logic                    w_border;
    logic signed [c_G_W-1:0] w_t [3][3];
    logic signed [c_G_W-1:0] w_gx, w_gy, r_gx, r_gy;
    logic [c_G_W-1:0]        w_ax, w_ay;
    logic [c_M_W-1:0]        w_mag;
    logic [PIX_W-1:0]        w_sat, w_res;
    logic                    w_hit;
    logic [3*PIX_W-1:0]      r_dout;

    assign w_din[0] = strm.din1;
    assign w_din[1] = strm.din2;
    assign w_din[2] = strm.din3;
    assign w_border = (r_col == '0) || (r_col == c_COL_W'(1));

    // Stage 0: window shift, column tracking, border tag per accepted sample
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++)
                    r_win[r][k] <= '0;
            r_col <= '0;
            r_v0  <= 1'b0;
            r_b0  <= 1'b0;
        end else begin
            r_v0 <= strm.valid_in;
            if (strm.valid_in) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= w_din[r];
                    r_win[r][1] <= r_win[r][0];
                    r_win[r][2] <= r_win[r][1];
                end
                r_b0  <= w_border;
                r_col <= (r_col == c_COL_LAST) ? '0 : r_col + 1'b1;
            end
        end
    end

    // Sobel doubles the centre-line terms; mode=1 turns the shift on
    always_comb begin
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                w_t[r][k] = signed'({3'b000, r_win[r][k]});
        w_gx = w_t[0][0] + (w_t[1][0] <<< mode) + w_t[2][0]
             - w_t[0][2] - (w_t[1][2] <<< mode) - w_t[2][2];
        w_gy = w_t[0][0] + (w_t[0][1] <<< mode) + w_t[0][2]
             - w_t[2][0] - (w_t[2][1] <<< mode) - w_t[2][2];
    end

    // Stage 1: gradient registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gx <= '0;
            r_gy <= '0;
            r_v1 <= 1'b0;
            r_b1 <= 1'b0;
        end else begin
            r_v1 <= r_v0;
            r_b1 <= r_b0;
            if (r_v0) begin
                r_gx <= w_gx;
                r_gy <= w_gy;
            end
        end
    end

    always_comb begin
        w_ax  = r_gx[c_G_W-1] ? $unsigned(-r_gx) : $unsigned(r_gx);
        w_ay  = r_gy[c_G_W-1] ? $unsigned(-r_gy) : $unsigned(r_gy);
        w_mag = {1'b0, w_ax} + {1'b0, w_ay};
        w_sat = (|w_mag[c_M_W-1:PIX_W]) ? '1 : w_mag[PIX_W-1:0];
        // Threshold compares against the full, unsaturated magnitude
        w_hit = (w_mag >= {4'b0000, thresh});
        w_res = bin_en ? {PIX_W{w_hit}} : w_sat;
    end

    // Stage 2: output register, holds between results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
            r_vout <= 1'b0;
        end else begin
            r_vout <= r_v1;
            if (r_v1)
                r_dout <= r_b1 ? '0 : {3{w_res}};
        end
    end

    assign strm.dout      = r_dout;
    assign strm.valid_out = r_vout;
endmodule
`default_nettype wire

// File: tb/tb_edge_grad_3x3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_edge_grad_3x3
//  Brief    : Directed and randomised checks of edge_grad_3x3 against a
//             sample-history reference model.
//  Revision : 1.0
// ============================================================================
module tb_edge_grad_3x3;
    localparam int PW = 8;
    localparam int W  = 8;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          mode   = 1'b0;
    logic          bin_en = 1'b0;
    logic [PW-1:0] thresh = '0;

    edge_grad_if #(.PIX_W(PW)) bus ();

    edge_grad_3x3 #(.PIX_W(PW), .PIC_WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .strm   (bus),
        .mode   (mode),
        .bin_en (bin_en),
        .thresh (thresh)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          h1[$], h2[$], h3[$];
    logic [23:0] q[$];
    logic [23:0] rec[$];
    logic [23:0] last = '0;
    bit          a0, a1, a2;

    // Result for accepted sample idx, from the last three accepted columns
    function automatic logic [23:0] model(int idx);
        int p [3][3];
        int wm, gx, gy, mag;
        logic [7:0] r8;
        if ((idx % W) < 2) return 24'h0;
        for (int k = 0; k < 3; k++) begin
            p[0][k] = h1[idx-k];
            p[1][k] = h2[idx-k];
            p[2][k] = h3[idx-k];
        end
        wm  = mode ? 2 : 1;
        gx  = (p[0][0] - p[0][2]) + wm * (p[1][0] - p[1][2]) + (p[2][0] - p[2][2]);
        gy  = (p[0][0] - p[2][0]) + wm * (p[0][1] - p[2][1]) + (p[0][2] - p[2][2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (bin_en) r8 = (mag >= int'(thresh)) ? 8'hFF : 8'h00;
        else        r8 = (mag > 255) ? 8'hFF : 8'(mag);
        return {3{r8}};
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input int a, input int b, input int c);
        logic [23:0] e;
        rst          = r;
        bus.valid_in = v;
        bus.din1     = 8'(a);
        bus.din2     = 8'(b);
        bus.din3     = 8'(c);
        @(posedge clk);
        if (r) begin
            h1.delete(); h2.delete(); h3.delete(); q.delete();
            a0 = 0; a1 = 0; a2 = 0; last = '0;
        end else begin
            a2 = a1; a1 = a0; a0 = v;
            if (v) begin
                h1.push_back(a & 255); h2.push_back(b & 255); h3.push_back(c & 255);
                q.push_back(model(h1.size() - 1));
            end
        end
        #1;
        chk("valid_out", {23'b0, bus.valid_out}, {23'b0, a2});
        if (a2 && q.size() > 0) begin
            e = q.pop_front();
            chk("dout", bus.dout, e);
            rec.push_back(bus.dout);
            last = e;
        end else begin
            chk("dout_hold", bus.dout, last);
        end
    endtask

    task automatic drain();
        repeat (3) step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        repeat (2) step(1, 0, 0, 0, 0);
        rec.delete();
    endtask

    // One line of a vertical step: lo for col 0..3, hi for col 4..7
    task automatic step_line(input int lo, input int hi, input bit gaps);
        int v;
        for (int c = 0; c < W; c++) begin
            if (gaps) step(0, 0, $urandom_range(255), $urandom_range(255), $urandom_range(255));
            v = (c < 4) ? lo : hi;
            step(0, 1, v, v, v);
        end
        drain();
    endtask

    task automatic chk_step_table(input string tag);
        chk({tag, "_cnt"}, 24'(rec.size()), 24'(W));
        for (int c = 0; c < W && c < rec.size(); c++)
            chk(tag, rec[c], (c == 4 || c == 5) ? 24'hFFFFFF : 24'h0);
    endtask

    initial begin
        bus.valid_in = 0; bus.din1 = 0; bus.din2 = 0; bus.din3 = 0;
        do_reset();

        // Flat image gives zero everywhere
        for (int c = 0; c < 2 * W; c++) step(0, 1, 100, 100, 100);
        drain();
        for (int i = 0; i < rec.size(); i++) chk("flat", rec[i], 24'h0);

        do_reset();
        step_line(0, 255, 0);
        chk_step_table("vstep");

        do_reset();
        step_line(200, 0, 0);
        chk_step_table("rstep");

        do_reset();
        step_line(0, 255, 1);
        chk_step_table("vstep_gaps");

        // Horizontal edge under each kernel / output-mode combination
        for (int cfg = 0; cfg < 5; cfg++) begin
            logic [23:0] hexp;
            case (cfg)
                0: begin mode = 0; bin_en = 0; thresh = 0;  hexp = 24'h3C3C3C; end
                1: begin mode = 1; bin_en = 0; thresh = 0;  hexp = 24'h505050; end
                2: begin mode = 0; bin_en = 1; thresh = 61; hexp = 24'h000000; end
                3: begin mode = 1; bin_en = 1; thresh = 61; hexp = 24'hFFFFFF; end
                default: begin mode = 0; bin_en = 1; thresh = 60; hexp = 24'hFFFFFF; end
            endcase
            do_reset();
            for (int c = 0; c < W; c++) step(0, 1, 20, 10, 0);
            drain();
            for (int c = 2; c < W && c < rec.size(); c++) chk("hedge", rec[c], hexp);
        end

        // Reset mid-line drops in-flight samples and restarts at col 0
        mode = 0; bin_en = 0; thresh = 0;
        do_reset();
        for (int c = 0; c < 4; c++) step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        rec.delete();
        for (int c = 0; c < W; c++) step(0, 1, 20, 10, 0);
        drain();
        chk("rst_cnt", 24'(rec.size()), 24'(W));
        if (rec.size() >= 3) begin
            chk("rst_col0", rec[0], 24'h0);
            chk("rst_col1", rec[1], 24'h0);
            chk("rst_col2", rec[2], 24'h3C3C3C);
        end

        // Randomised segments; controls change only while the pipe is empty
        for (int seg = 0; seg < 6; seg++) begin
            mode   = 1'($urandom_range(1));
            bin_en = 1'($urandom_range(1));
            thresh = 8'($urandom_range(255));
            if (seg == 3) do_reset();
            for (int i = 0; i < 60; i++)
                step(0, ($urandom_range(3) != 0), $urandom_range(255),
                     $urandom_range(255), $urandom_range(255));
            drain();
        end
        chk("queue_empty", 24'(q.size()), 24'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
